vga_frame_scanner: RTL and testbench
====================================

// Module: vga_frame_scanner
// PURPOSE
//  Downstream consumer of the CPU pixel port. Generates 640x480@60 VGA timing from the 25 MHz
//  vga clock and drives the framebuffer read address (RAM port B, 256x256 x 8-bit image).
//  It receives the 8-bit grayscale pixel from that port, centres the image on screen with a
//  black border, and drives registered sync, blank and RGB signals to the DAC.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line     | H_FP 16  | H_SYNC 96  | H_BP 48  (line = 800)
//  V_ACTIVE 480  visible lines per frame     | V_FP 10  | V_SYNC 2   | V_BP 33  (frame = 525)
//  IMG_W 256, IMG_H 256   image size; power of two, each <= 256
//  IMG_X0 192, IMG_Y0 112 top-left corner of the image window, in active-area coordinates
//  RAM_LAT 2              cycles from pixel_addr change to matching pixel_in (>=1)
//  BORDER 8'h00           gray level outside the window
// PORTS
//  clk        in   1   vga pixel clock, 25 MHz; all logic on posedge
//  reset      in   1   synchronous reset, active-low
//  enable     in   1   VGA enable switch; 0 = display blanked to BORDER, timing keeps running
//  pixel_in   in   8   framebuffer read data (RAM q_b)
//  pixel_addr out  16  framebuffer read address = {row[7:0], col[7:0]}
//  hsync      out  1   horizontal sync, active-low
//  vsync      out  1   vertical sync, active-low
//  blank_n    out  1   1 inside the 640x480 active area
//  sync_n     out  1   tied 0 (DAC composite sync unused), registered
//  red/green/blue out 8 each; gray level, all three equal
//  frame_start out 1   one-cycle pulse aligned to output pixel (0,0)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): h_cnt=0, v_cnt=0, pixel_addr=0, hsync=vsync=1,
//    blank_n=0, rgb=0, frame_start=0. All delay-pipeline stages are cleared to these values.
//    Reset mid-line or mid-frame aborts immediately; counting restarts at (0,0) on the first
//    cycle after release.
//  - h_cnt counts 0..799 and wraps to 0. v_cnt increments only when h_cnt wraps, counts
//    0..524, and wraps to 0. Active area: h<640 && v<480.
//    Sync low for h in [656,751] and for v in [490,491].
//  - Window: in_win = enable && h in [IMG_X0, IMG_X0+IMG_W-1] && v in [IMG_Y0, IMG_Y0+IMG_H-1].
//  - Address stage: pixel_addr is registered from the cycle-t counters and is valid at t+1.
//    When in_win: pixel_addr = ((v-IMG_Y0)<<8) | (h-IMG_X0), with 8-bit fields.
//    Outside the window: pixel_addr holds its last value. When enable==0: pixel_addr=0.
//  - Alignment: the counter position of cycle t appears on all display outputs at t+2+RAM_LAT.
//    * pixel_in is sampled at t+1+RAM_LAT and registered.
//    * hsync, vsync, blank_n and in_win travel through a matched shift pipeline of depth
//      2+RAM_LAT.
//  - RGB: delayed in_win -> r=g=b=pixel_in registered; delayed active && !in_win -> BORDER;
//    blanking -> 0.
//  - frame_start: high for exactly one cycle when the delayed position is (0,0), once per
//    420000 cycles.
//  - enable is sampled per pixel. Toggling it mid-frame takes effect at the next pixel;
//    sync timing is never disturbed.
//  - No handshake with the CPU. The RAM read port is free-running and read-only.
// TESTING
//  1 Reset, then release at cycle 0 -> first hsync falling edge at cycle 656+2+RAM_LAT;
//    hsync low for 96 cycles; period 800 cycles.
//  2 Run 2 frames -> vsync low for 1600 cycles starting at line 490; frame_start period is
//    420000; blank_n high 640 of every 800 cycles on lines 0..479 only.
//  3 enable=1, RAM model returns addr[7:0] -> counter (192,112) gives pixel_addr=0x0000;
//    counter (447,367) gives 0xFFFF; rgb at (192,112) is 0x00 and at (200,112) is 0x08,
//    each 2+RAM_LAT cycles later.
//  4 Position (191,112) and (448,112) -> rgb=BORDER; pixel_addr at 448 equals 0x00FF (held).
//  5 enable dropped at counter (300,200) -> from the next cycle pixel_addr=0; rgb=BORDER in
//    the active area; hsync and vsync cadence unchanged.
//  6 reset asserted at counter (400,300) for 3 cycles -> outputs reach their reset values,
//    and after release the h_cnt/v_cnt sequence restarts at (0,0); hsync timing follows
//    scenario 1.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// VGA 640x480@60 frame scanner: generates sync/blank timing, reads a centred grayscale
// image from a free-running framebuffer read port and drives registered DAC signals.
module vga_frame_scanner #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          IMG_W    = 256,
   parameter int          IMG_H    = 256,
   parameter int          IMG_X0   = 192,
   parameter int          IMG_Y0   = 112,
   parameter int          RAM_LAT  = 2,
   parameter logic [7:0]  BORDER   = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  pixel_in,
   output logic [15:0] pixel_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic        sync_n,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   // Flag pipeline is one stage shorter than the total delay; the output register is the last.
   localparam int P       = RAM_LAT + 1;

   localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_WIN_BEG  = HW'(IMG_X0);
   localparam logic [HW-1:0] H_WIN_END  = HW'(IMG_X0 + IMG_W);

   localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_WIN_BEG  = VW'(IMG_Y0);
   localparam logic [VW-1:0] V_WIN_END  = VW'(IMG_Y0 + IMG_H);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   logic          active_now;
   logic          hs_now;
   logic          vs_now;
   logic          in_win;
   logic          origin_now;
   logic [7:0]    col_off;
   logic [7:0]    row_off;

   logic [P-1:0]  hs_pipe;
   logic [P-1:0]  vs_pipe;
   logic [P-1:0]  act_pipe;
   logic [P-1:0]  win_pipe;
   logic [P-1:0]  org_pipe;
   logic [7:0]    gray;

   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_MAX) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   assign active_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_now     = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
   assign vs_now     = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
   assign in_win     = enable
                       && (h_cnt >= H_WIN_BEG) && (h_cnt < H_WIN_END)
                       && (v_cnt >= V_WIN_BEG) && (v_cnt < V_WIN_END);
   assign origin_now = (h_cnt == '0) && (v_cnt == '0);

   // Offsets are only meaningful inside the window, where they are non-negative and < 256.
   assign col_off = 8'(h_cnt - H_WIN_BEG);
   assign row_off = 8'(v_cnt - V_WIN_BEG);

   // The RAM read port is free-running with no handshake; outside the window the address holds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pixel_addr <= '0;
      end else if (!enable) begin
         pixel_addr <= '0;
      end else if (in_win) begin
         pixel_addr <= {row_off, col_off};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hs_pipe  <= '1;
         vs_pipe  <= '1;
         act_pipe <= '0;
         win_pipe <= '0;
         org_pipe <= '0;
      end else begin
         hs_pipe  <= {hs_pipe[P-2:0],  hs_now};
         vs_pipe  <= {vs_pipe[P-2:0],  vs_now};
         act_pipe <= {act_pipe[P-2:0], active_now};
         win_pipe <= {win_pipe[P-2:0], in_win};
         org_pipe <= {org_pipe[P-2:0], origin_now};
      end
   end

   // Last pipeline stage lines up with pixel_in for the same counter position.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank_n     <= 1'b0;
         sync_n      <= 1'b0;
         frame_start <= 1'b0;
         gray        <= 8'h00;
      end else begin
         hsync       <= hs_pipe[P-1];
         vsync       <= vs_pipe[P-1];
         blank_n     <= act_pipe[P-1];
         sync_n      <= 1'b0;
         frame_start <= org_pipe[P-1];
         if (win_pipe[P-1]) begin
            gray <= pixel_in;
         end else if (act_pipe[P-1]) begin
            gray <= BORDER;
         end else begin
            gray <= 8'h00;
         end
      end
   end

   assign red   = gray;
   assign green = gray;
   assign blue  = gray;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner, full horizontal timing with a short frame
// (10 lines, 4-row image starting at line 1) so several frames fit in one run.
module tb_vga_frame_scanner;

   localparam logic [7:0] BRD = 8'h5A;
   localparam logic [23:0] BRD3 = {BRD, BRD, BRD};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic [7:0]  pixel_in = 8'h00;
   logic [7:0]  ram_q1 = 8'h00;
   logic [15:0] pixel_addr;
   logic        hsync;
   logic        vsync;
   logic        blank_n;
   logic        sync_n;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;
   logic        frame_start;
   logic [23:0] rgb;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   assign rgb = {red, green, blue};

   vga_frame_scanner #(
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .IMG_H(4), .IMG_Y0(1), .RAM_LAT(2), .BORDER(BRD)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
      .pixel_addr(pixel_addr), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
      .sync_n(sync_n), .red(red), .green(green), .blue(blue), .frame_start(frame_start)
   );

   always #20 clk = ~clk;

   // Two-cycle read latency RAM returning the low address byte.
   always @(posedge clk) begin
      ram_q1   <= pixel_addr[7:0];
      pixel_in <= ram_q1;
   end

   // Counter position index since the last reset release.
   always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

   task automatic goto_cycle(input int target);
      int guard;
      guard = 0;
      if (cyc > target) begin
         vectors++;
         miscompares++;
         $display("FAIL goto: cycle %0d already past target %0d", cyc, target);
      end
      while (cyc < target && guard < 60000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < target) begin
         vectors++;
         miscompares++;
         $display("FAIL goto_timeout: cycle %0d never reached %0d", cyc, target);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      enable = 1'b1;
      repeat (6) @(negedge clk);
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", pixel_addr); end
      vectors++; if (hsync !== 1'b1) begin miscompares++; $display("FAIL reset_hsync: got %b want 1", hsync); end
      vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL reset_vsync: got %b want 1", vsync); end
      vectors++; if (blank_n !== 1'b0) begin miscompares++; $display("FAIL reset_blank: got %b want 0", blank_n); end
      vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", frame_start); end
      vectors++; if (sync_n !== 1'b0) begin miscompares++; $display("FAIL reset_sync_n: got %b want 0", sync_n); end
      reset = 1'b1;
   endtask

   // Expects to be entered in the cycle right after reset release.
   task automatic test_hsync_timing();
      int   fall1, rise1, fall2;
      logic prev;
      fall1 = -1; rise1 = -1; fall2 = -1;
      goto_cycle(3);
      vectors++; if (blank_n !== 1'b0) begin miscompares++; $display("FAIL hs_blank3: got %b want 0", blank_n); end
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL hs_fs3: got %b want 0", frame_start); end
      vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL hs_rgb3: got %h want 000000", rgb); end
      goto_cycle(4);
      vectors++; if (blank_n !== 1'b1) begin miscompares++; $display("FAIL hs_blank4: got %b want 1", blank_n); end
      vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL hs_fs4: got %b want 1", frame_start); end
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL hs_rgb4: got %h want %h", rgb, BRD3); end
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL hs_addr4: got %h want 0000", pixel_addr); end
      goto_cycle(5);
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL hs_fs5: got %b want 0", frame_start); end
      prev = hsync;
      for (int n = 6; n <= 1700; n++) begin
         goto_cycle(n);
         if (prev === 1'b1 && hsync === 1'b0) begin
            if (fall1 < 0) fall1 = n;
            else if (fall2 < 0) fall2 = n;
         end
         if (prev === 1'b0 && hsync === 1'b1 && rise1 < 0) rise1 = n;
         prev = hsync;
      end
      vectors++; if (fall1 != 660) begin miscompares++; $display("FAIL hs_fall1: got %0d want 660", fall1); end
      vectors++; if (rise1 != 756) begin miscompares++; $display("FAIL hs_rise1: got %0d want 756", rise1); end
      vectors++; if (fall2 != 1460) begin miscompares++; $display("FAIL hs_fall2: got %0d want 1460", fall2); end
   endtask

   task automatic test_frame_timing();
      int   vs_low, hs_low, blank_hi, blank_bad, fs_cnt, fs1, fs2, vf1, vf2;
      int   p, line, col;
      logic prev_vs, exp_blank;
      vs_low = 0; hs_low = 0; blank_hi = 0; blank_bad = 0; fs_cnt = 0;
      fs1 = -1; fs2 = -1; vf1 = -1; vf2 = -1;
      goto_cycle(1700);
      prev_vs = vsync;
      for (int n = 1701; n <= 17700; n++) begin
         goto_cycle(n);
         p = n - 4;
         line = (p / 800) % 10;
         col = p % 800;
         exp_blank = (line < 6) && (col < 640);
         if (blank_n !== exp_blank) blank_bad++;
         if (blank_n === 1'b1) blank_hi++;
         if (vsync === 1'b0) vs_low++;
         if (hsync === 1'b0) hs_low++;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs1 < 0) fs1 = n; else if (fs2 < 0) fs2 = n;
         end
         if (prev_vs === 1'b1 && vsync === 1'b0) begin
            if (vf1 < 0) vf1 = n; else if (vf2 < 0) vf2 = n;
         end
         prev_vs = vsync;
      end
      vectors++; if (vs_low != 3200) begin miscompares++; $display("FAIL fr_vs_low: got %0d want 3200", vs_low); end
      vectors++; if (hs_low != 1920) begin miscompares++; $display("FAIL fr_hs_low: got %0d want 1920", hs_low); end
      vectors++; if (blank_hi != 7680) begin miscompares++; $display("FAIL fr_blank_hi: got %0d want 7680", blank_hi); end
      vectors++; if (blank_bad != 0) begin miscompares++; $display("FAIL fr_blank_pos: got %0d bad cycles want 0", blank_bad); end
      vectors++; if (fs_cnt != 2) begin miscompares++; $display("FAIL fr_fs_cnt: got %0d want 2", fs_cnt); end
      vectors++; if (fs1 != 8004) begin miscompares++; $display("FAIL fr_fs1: got %0d want 8004", fs1); end
      vectors++; if (fs2 != 16004) begin miscompares++; $display("FAIL fr_fs2: got %0d want 16004", fs2); end
      vectors++; if (vf1 != 5604) begin miscompares++; $display("FAIL fr_vs_fall1: got %0d want 5604", vf1); end
      vectors++; if (vf2 != 13604) begin miscompares++; $display("FAIL fr_vs_fall2: got %0d want 13604", vf2); end
   endtask

   task automatic test_window();
      goto_cycle(24993);
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL win_addr_first: got %h want 0000", pixel_addr); end
      goto_cycle(24996);
      vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL win_rgb_192: got %h want 000000", rgb); end
      vectors++; if (blank_n !== 1'b1) begin miscompares++; $display("FAIL win_blank_192: got %b want 1", blank_n); end
      goto_cycle(25004);
      vectors++; if (rgb !== 24'h080808) begin miscompares++; $display("FAIL win_rgb_200: got %h want 080808", rgb); end
      goto_cycle(26651);
      vectors++; if (pixel_addr !== 16'h023A) begin miscompares++; $display("FAIL win_addr_mid: got %h want 023a", pixel_addr); end
      goto_cycle(26654);
      vectors++; if (rgb !== 24'h3A3A3A) begin miscompares++; $display("FAIL win_rgb_mid: got %h want 3a3a3a", rgb); end
      goto_cycle(27648);
      vectors++; if (pixel_addr !== 16'h03FF) begin miscompares++; $display("FAIL win_addr_last: got %h want 03ff", pixel_addr); end
      goto_cycle(27651);
      vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL win_rgb_last: got %h want ffffff", rgb); end
   endtask

   task automatic test_border();
      goto_cycle(32104);
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL bd_rgb_row0: got %h want %h", rgb, BRD3); end
      goto_cycle(32992);
      vectors++; if (pixel_addr !== 16'h03FF) begin miscompares++; $display("FAIL bd_addr_held: got %h want 03ff", pixel_addr); end
      goto_cycle(32995);
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL bd_rgb_191: got %h want %h", rgb, BRD3); end
      goto_cycle(33249);
      vectors++; if (pixel_addr !== 16'h00FF) begin miscompares++; $display("FAIL bd_addr_448: got %h want 00ff", pixel_addr); end
      goto_cycle(33252);
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL bd_rgb_448: got %h want %h", rgb, BRD3); end
      goto_cycle(33504);
      vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL bd_rgb_hblank: got %h want 000000", rgb); end
      vectors++; if (blank_n !== 1'b0) begin miscompares++; $display("FAIL bd_blank_hblank: got %b want 0", blank_n); end
   endtask

   task automatic test_enable_drop();
      int   fall, rise;
      logic prev;
      fall = -1; rise = -1;
      goto_cycle(42699);
      vectors++; if (pixel_addr !== 16'h026A) begin miscompares++; $display("FAIL en_addr_298: got %h want 026a", pixel_addr); end
      goto_cycle(42700);
      vectors++; if (pixel_addr !== 16'h026B) begin miscompares++; $display("FAIL en_addr_299: got %h want 026b", pixel_addr); end
      enable = 1'b0;
      goto_cycle(42701);
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL en_addr_off: got %h want 0000", pixel_addr); end
      goto_cycle(42703);
      vectors++; if (rgb !== 24'h6B6B6B) begin miscompares++; $display("FAIL en_rgb_last: got %h want 6b6b6b", rgb); end
      goto_cycle(42704);
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL en_rgb_off: got %h want %h", rgb, BRD3); end
      prev = hsync;
      for (int n = 42705; n <= 43200; n++) begin
         goto_cycle(n);
         if (prev === 1'b1 && hsync === 1'b0 && fall < 0) fall = n;
         if (prev === 1'b0 && hsync === 1'b1 && rise < 0) rise = n;
         prev = hsync;
      end
      vectors++; if (fall != 43060) begin miscompares++; $display("FAIL en_hs_fall: got %0d want 43060", fall); end
      vectors++; if (rise != 43156) begin miscompares++; $display("FAIL en_hs_rise: got %0d want 43156", rise); end
      goto_cycle(43504);
      vectors++; if (rgb !== BRD3) begin miscompares++; $display("FAIL en_rgb_next: got %h want %h", rgb, BRD3); end
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL en_addr_next: got %h want 0000", pixel_addr); end
      goto_cycle(45603);
      vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL en_vs_before: got %b want 1", vsync); end
      goto_cycle(45604);
      vectors++; if (vsync !== 1'b0) begin miscompares++; $display("FAIL en_vs_fall: got %b want 0", vsync); end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      goto_cycle(50800);
      vectors++; if (rgb !== 24'hCCCCCC) begin miscompares++; $display("FAIL rm_rgb_pre: got %h want cccccc", rgb); end
      vectors++; if (pixel_addr !== 16'h02CF) begin miscompares++; $display("FAIL rm_addr_pre: got %h want 02cf", pixel_addr); end
      reset = 1'b0;
      @(negedge clk);
      vectors++; if (pixel_addr !== 16'h0000) begin miscompares++; $display("FAIL rm_addr: got %h want 0000", pixel_addr); end
      vectors++; if (hsync !== 1'b1) begin miscompares++; $display("FAIL rm_hsync: got %b want 1", hsync); end
      vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL rm_vsync: got %b want 1", vsync); end
      vectors++; if (blank_n !== 1'b0) begin miscompares++; $display("FAIL rm_blank: got %b want 0", blank_n); end
      vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL rm_rgb: got %h want 000000", rgb); end
      vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rm_fs: got %b want 0", frame_start); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      test_hsync_timing();
   endtask

   initial begin
      test_reset();
      test_hsync_timing();
      test_frame_timing();
      test_window();
      test_border();
      test_enable_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
